// File: rtl/jt12_slot_seq.sv
// Slot sequencer and write/clear controller for the FM operator state ring.
// Optional readback port set enabled by defining JT12_SLOT_SEQ_RDBACK_EN.
module jt12_slot_seq #(
  parameter int WIDTH    = 10,
  parameter int SLOTS    = 24,
  parameter int CHANNELS = 6,
  parameter int OPS      = 4,
  parameter logic [WIDTH-1:0] CLRVAL = '0
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             clk_en,
  input  logic [WIDTH-1:0] loop_in,
  output logic [WIDTH-1:0] loop_out,
  output logic [4:0]       cur_slot,
  output logic [2:0]       cur_ch,
  output logic [1:0]       cur_op,
  output logic             zero,
  input  logic             wr_req,
  input  logic [4:0]       wr_slot,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_req,
  output logic             busy,
  output logic             wr_ack,
`ifdef JT12_SLOT_SEQ_RDBACK_EN
  input  logic             rd_req,
  input  logic [4:0]       rd_slot,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
`endif
  output logic             wr_err
);

  localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);
  localparam logic [2:0] CH_LAST   = 3'(CHANNELS - 1);
  localparam logic [1:0] OP_LAST   = 2'(OPS - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT, CLEAR, DONE
`ifdef JT12_SLOT_SEQ_RDBACK_EN
    , RWAIT
`endif
  } state_t;

  state_t           state;
  logic [4:0]       tgt;
  logic [WIDTH-1:0] data;
  logic [4:0]       sweep;
  logic             hit;

  assign zero = (cur_slot == 5'd0);
  assign hit  = clk_en && (cur_slot == tgt);

  // Channel/operator kept as chained counters so no divider is needed
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_slot <= '0;
      cur_ch   <= '0;
      cur_op   <= '0;
    end else if (clk_en) begin
      cur_slot <= (cur_slot == SLOT_LAST) ? 5'd0 : cur_slot + 5'd1;
      if (cur_ch == CH_LAST) begin
        cur_ch <= '0;
        cur_op <= (cur_op == OP_LAST) ? 2'd0 : cur_op + 2'd1;
      end else begin
        cur_ch <= cur_ch + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
      tgt    <= '0;
      data   <= '0;
      sweep  <= '0;
`ifdef JT12_SLOT_SEQ_RDBACK_EN
      rd_data  <= '0;
      rd_valid <= 1'b0;
`endif
    end else begin
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
`ifdef JT12_SLOT_SEQ_RDBACK_EN
      rd_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (clk_en) begin
            if (clr_req) begin
              sweep <= '0;
              state <= CLEAR;
              busy  <= 1'b1;
            end else if (wr_req) begin
              if (wr_slot > SLOT_LAST) begin
                wr_err <= 1'b1;
              end else begin
                tgt   <= wr_slot;
                data  <= wr_data;
                state <= WAIT;
                busy  <= 1'b1;
              end
            end
`ifdef JT12_SLOT_SEQ_RDBACK_EN
            else if (rd_req) begin
              if (rd_slot > SLOT_LAST) begin
                wr_err <= 1'b1;
              end else begin
                tgt   <= rd_slot;
                state <= RWAIT;
                busy  <= 1'b1;
              end
            end
`endif
          end
        end
        // The latch happened in IDLE, so a match here is always a later pass
        WAIT: begin
          if (hit) begin
            state  <= DONE;
            wr_ack <= 1'b1;
          end
        end
        CLEAR: begin
          if (clk_en) begin
            if (sweep == SLOT_LAST) begin
              state  <= DONE;
              wr_ack <= 1'b1;
            end else begin
              sweep <= sweep + 5'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
`ifdef JT12_SLOT_SEQ_RDBACK_EN
        RWAIT: begin
          if (hit) begin
            rd_data  <= loop_in;
            rd_valid <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    loop_out = loop_in;
    if (state == CLEAR)
      loop_out = CLRVAL;
    else if (state == WAIT && hit)
      loop_out = data;
  end

endmodule

// File: tb/tb_jt12_slot_seq.sv
// Directed bench for jt12_slot_seq with a behavioural 24-deep ring closing the loop.
module tb_jt12_slot_seq;

  logic       rst, clk, clk_en;
  logic [9:0] loop_in, loop_out;
  logic [4:0] cur_slot;
  logic [2:0] cur_ch;
  logic [1:0] cur_op;
  logic       zero;
  logic       wr_req;
  logic [4:0] wr_slot;
  logic [9:0] wr_data;
  logic       clr_req, busy, wr_ack, wr_err;

  int checks = 0;
  int errors = 0;
  int es = 0;
  int tgt7;

  logic [9:0] ring [24];
  logic [4:0] ms;

  jt12_slot_seq dut (
    .rst(rst), .clk(clk), .clk_en(clk_en),
    .loop_in(loop_in), .loop_out(loop_out),
    .cur_slot(cur_slot), .cur_ch(cur_ch), .cur_op(cur_op), .zero(zero),
    .wr_req(wr_req), .wr_slot(wr_slot), .wr_data(wr_data),
    .clr_req(clr_req), .busy(busy), .wr_ack(wr_ack), .wr_err(wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] init_val(input int i);
    return 10'(i * 37 + 5);
  endfunction

  // Ring storage: slot ms is presented on loop_in and rewritten from loop_out
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 24; i++) ring[i] <= init_val(i);
      ms <= 5'd0;
    end else if (clk_en) begin
      ring[ms] <= loop_out;
      ms <= (ms == 5'd23) ? 5'd0 : ms + 5'd1;
    end
  end
  assign loop_in = ring[ms];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) es = 0;
    else if (clk_en) es = (es == 23) ? 0 : es + 1;
    #1;
  endtask

  task automatic adv_to(input int s);
    for (int k = 0; k < 48 && es != s; k++) tick();
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b0; wr_req = 1'b0; wr_slot = '0; wr_data = '0; clr_req = 1'b0;
    tick(); tick();
    check("rst_slot", 32'(cur_slot), 0);
    check("rst_ch", 32'(cur_ch), 0);
    check("rst_op", 32'(cur_op), 0);
    check("rst_zero", 32'(zero), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_ack", 32'(wr_ack), 0);
    check("rst_err", 32'(wr_err), 0);
    check("rst_pass", 32'(loop_out), 32'(loop_in));
    rst = 1'b0; clk_en = 1'b1;

    for (int c = 0; c < 30; c++) begin
      check("cnt_slot", 32'(cur_slot), 32'(c % 24));
      check("cnt_ch", 32'(cur_ch), 32'((c % 24) % 6));
      check("cnt_op", 32'(cur_op), 32'((c % 24) / 6));
      check("cnt_zero", 32'(zero), 32'((c % 24) == 0));
      tick();
    end

    // Write 0x155 to slot 10, latched at slot 3
    adv_to(3);
    wr_req = 1'b1; wr_slot = 5'd10; wr_data = 10'h155;
    check("wr_idle_pass", 32'(loop_out), 32'(loop_in));
    tick();
    wr_req = 1'b0;
    check("wr_busy", 32'(busy), 1);
    while (es != 10) begin
      check("wr_wait_pass", 32'(loop_out), 32'(loop_in));
      check("wr_wait_ack", 32'(wr_ack), 0);
      tick();
    end
    check("wr_commit", 32'(loop_out), 32'h155);
    tick();
    check("wr_ack", 32'(wr_ack), 1);
    check("wr_done_busy", 32'(busy), 1);
    tick();
    check("wr_ack_end", 32'(wr_ack), 0);
    check("wr_idle_busy", 32'(busy), 0);
    adv_to(9);
    check("ring_slot9", 32'(loop_out), 32'(init_val(9)));
    tick();
    check("ring_slot10", 32'(loop_out), 32'h155);

    // Write latched while its own slot is current: commits one rotation later
    adv_to(5);
    wr_req = 1'b1; wr_slot = 5'd5; wr_data = 10'h2AA;
    check("latch_nocommit", 32'(loop_out), 32'(loop_in));
    tick();
    wr_req = 1'b0;
    for (int k = 0; k < 23; k++) begin
      check("latch_wait_pass", 32'(loop_out), 32'(loop_in));
      check("latch_wait_ack", 32'(wr_ack), 0);
      tick();
    end
    check("latch_slot", 32'(cur_slot), 5);
    check("latch_commit", 32'(loop_out), 32'h2AA);
    tick();
    check("latch_ack", 32'(wr_ack), 1);
    tick();
    check("latch_idle", 32'(busy), 0);

    // Clear and write requested together: clear wins
    clr_req = 1'b1; wr_req = 1'b1; wr_slot = 5'd2; wr_data = 10'h3FF;
    tick();
    clr_req = 1'b0; wr_req = 1'b0;
    check("clr_busy", 32'(busy), 1);
    for (int k = 0; k < 24; k++) begin
      check("clr_out", 32'(loop_out), 32'(10'd0));
      check("clr_noack", 32'(wr_ack), 0);
      tick();
    end
    check("clr_ack", 32'(wr_ack), 1);
    tick();
    check("clr_ack_end", 32'(wr_ack), 0);
    check("clr_idle", 32'(busy), 0);
    for (int k = 0; k < 24; k++) begin
      check("clr_ring_zero", 32'(loop_out), 32'(10'd0));
      tick();
    end

    // Out-of-range slot
    wr_req = 1'b1; wr_slot = 5'd30; wr_data = 10'h111;
    check("err_pass0", 32'(loop_out), 32'(loop_in));
    tick();
    wr_req = 1'b0;
    check("err_pulse", 32'(wr_err), 1);
    check("err_busy", 32'(busy), 0);
    check("err_pass1", 32'(loop_out), 32'(loop_in));
    tick();
    check("err_end", 32'(wr_err), 0);
    check("err_busy2", 32'(busy), 0);

    // clk_en toggling in WAIT, then reset abandons the write
    tgt7 = (es + 20) % 24;
    wr_req = 1'b1; wr_slot = 5'(tgt7); wr_data = 10'h0F0;
    tick();
    wr_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      clk_en = 1'b0;
      tick();
      check("hold_slot", 32'(cur_slot), 32'(es));
      check("hold_busy", 32'(busy), 1);
      check("hold_pass", 32'(loop_out), 32'(loop_in));
      clk_en = 1'b1;
      tick();
      check("run_slot", 32'(cur_slot), 32'(es));
      check("run_ack", 32'(wr_ack), 0);
    end
    rst = 1'b1;
    tick();
    check("mid_rst_slot", 32'(cur_slot), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ack", 32'(wr_ack), 0);
    rst = 1'b0;
    for (int k = 0; k < 26; k++) begin
      check("post_rst_pass", 32'(loop_out), 32'(loop_in));
      check("post_rst_ack", 32'(wr_ack), 0);
      check("post_rst_slot", 32'(cur_slot), 32'(es));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
